// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Holds the FSM state encoding, bus widths and PSEL slot decode.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int NSLOT  = 16;

  function automatic logic [NSLOT-1:0] slot_decode(
    input logic [3:0] slot
  );
    slot_decode = '0;
    slot_decode[slot] = 1'b1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin pick: first eligible request at or after ptr.
// The pointer register lives in the parent.
module apb_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  int              w_j;

  assign w_elig = req & ~mask;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(ptr) + k) % NREQ;
      if (!w_found && w_elig[w_j]) begin
        w_found     = 1'b1;
        grant[w_j]  = 1'b1;
        idx         = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin share of one APB3 master port among NREQ requesters,
// with SETUP/ACCESS sequencing, PSEL slot decode and PREADY timeout.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SLOT_LSB = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      REQ_WRITE,
  input  logic [NREQ*32-1:0]   REQ_ADDR,
  input  logic [NREQ*32-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      REQ_ACK,
  output logic [APB_DW-1:0]    REQ_RDATA,
  output logic                 REQ_ERR,
  output logic                 BUSY,
  output logic [APB_AW-1:0]    PADDR,
  output logic [NSLOT-1:0]     PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [APB_DW-1:0]    PWDATA,
  input  logic [APB_DW-1:0]    PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              r_state, w_state_n;
  logic [IW-1:0]       r_ptr, w_ptr_n;
  logic [IW-1:0]       r_gidx, w_gidx_n;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic [NREQ-1:0]     r_ack, w_ack_n;
  logic [APB_DW-1:0]   r_rdata, w_rdata_n;
  logic                r_err, w_err_n;
  logic                r_busy, w_busy_n;
  logic [APB_AW-1:0]   r_paddr, w_paddr_n;
  logic [NSLOT-1:0]    r_psel, w_psel_n;
  logic                r_penable, w_penable_n;
  logic                r_pwrite, w_pwrite_n;
  logic [APB_DW-1:0]   r_pwdata, w_pwdata_n;

  logic [NREQ-1:0]     w_grant;
  logic [IW-1:0]       w_gidx;
  logic                w_tout;
  logic [APB_AW-1:0]   w_addr_a  [NREQ];
  logic [APB_DW-1:0]   w_wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_a[g]  = REQ_ADDR[32*g +: 32];
    assign w_wdata_a[g] = REQ_WDATA[32*g +: 32];
  end

  // The requester acked this cycle may not win again straight away.
  apb_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (REQ),
    .mask  (r_ack),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_gidx)
  );

  assign w_tout = (TIMEOUT != 0) && !PREADY &&
                  (r_cnt == CW'(TIMEOUT));

  always_comb begin
    w_state_n   = r_state;
    w_ptr_n     = r_ptr;
    w_gidx_n    = r_gidx;
    w_cnt_n     = r_cnt;
    w_ack_n     = '0;
    w_rdata_n   = '0;
    w_err_n     = 1'b0;
    w_busy_n    = r_busy;
    w_paddr_n   = r_paddr;
    w_psel_n    = r_psel;
    w_penable_n = r_penable;
    w_pwrite_n  = r_pwrite;
    w_pwdata_n  = r_pwdata;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_gidx_n    = w_gidx;
          w_paddr_n   = w_addr_a[w_gidx];
          w_pwdata_n  = w_wdata_a[w_gidx];
          w_pwrite_n  = REQ_WRITE[w_gidx];
          w_psel_n    = slot_decode(
                          w_addr_a[w_gidx][SLOT_LSB +: 4]);
          w_penable_n = 1'b0;
          w_busy_n    = 1'b1;
          w_ptr_n     = (w_gidx == IW'(NREQ - 1)) ?
                        '0 : w_gidx + 1'b1;
          w_state_n   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_penable_n = 1'b1;
        w_state_n   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY || w_tout) begin
          w_ack_n[r_gidx] = 1'b1;
          w_rdata_n   = (PREADY && !r_pwrite) ? PRDATA : '0;
          w_err_n     = PREADY ? PSLVERR : 1'b1;
          w_psel_n    = '0;
          w_penable_n = 1'b0;
          w_busy_n    = 1'b0;
          w_cnt_n     = '0;
          w_state_n   = ST_IDLE;
        end else if (!(&r_cnt)) begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_paddr   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_gidx    <= w_gidx_n;
      r_cnt     <= w_cnt_n;
      r_ack     <= w_ack_n;
      r_rdata   <= w_rdata_n;
      r_err     <= w_err_n;
      r_busy    <= w_busy_n;
      r_paddr   <= w_paddr_n;
      r_psel    <= w_psel_n;
      r_penable <= w_penable_n;
      r_pwrite  <= w_pwrite_n;
      r_pwdata  <= w_pwdata_n;
    end
  end

  assign REQ_ACK   = r_ack;
  assign REQ_RDATA = r_rdata;
  assign REQ_ERR   = r_err;
  assign BUSY      = r_busy;
  assign PADDR     = r_paddr;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: one default instance plus a
// TIMEOUT=4 instance sharing the same stimulus.
module tb_apb_master_arbiter;

  logic         PCLK;
  logic         PRESETN;
  logic [3:0]   REQ, REQ_WRITE;
  logic [127:0] REQ_ADDR, REQ_WDATA;
  logic [31:0]  PRDATA;
  logic         PREADY, PSLVERR;

  logic [3:0]   ack_a, ack_b;
  logic [31:0]  rd_a, rd_b;
  logic         err_a, err_b, busy_a, busy_b;
  logic [31:0]  paddr_a, paddr_b, pwd_a, pwd_b;
  logic [15:0]  psel_a, psel_b;
  logic         pen_a, pen_b, pwr_a, pwr_b;

  int n_pass = 0;
  int n_total = 0;

  apb_master_arbiter #(.NREQ(4), .SLOT_LSB(8), .TIMEOUT(255)) dut_a (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_ACK(ack_a),
    .REQ_RDATA(rd_a), .REQ_ERR(err_a), .BUSY(busy_a), .PADDR(paddr_a),
    .PSEL(psel_a), .PENABLE(pen_a), .PWRITE(pwr_a), .PWDATA(pwd_a),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_arbiter #(.NREQ(4), .SLOT_LSB(8), .TIMEOUT(4)) dut_b (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_ACK(ack_b),
    .REQ_RDATA(rd_b), .REQ_ERR(err_b), .BUSY(busy_b), .PADDR(paddr_b),
    .PSEL(psel_b), .PENABLE(pen_b), .PWRITE(pwr_b), .PWDATA(pwd_b),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge PCLK);
  endtask

  task automatic do_reset;
    PRESETN = 1'b0;
    REQ = '0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    tick();
    tick();
    PRESETN = 1'b1;
  endtask

  task automatic test_reset;
    REQ = 4'hF;
    REQ_ADDR = {4{32'h0000_0F00}};
    PREADY = 1'b1;
    PRESETN = 1'b0;
    tick();
    tick();
    n_total++;
    if ({ack_a, rd_a, err_a, busy_a} !== '0)
      $display("FAIL reset_resp: got %h/%h/%b/%b want 0",
               ack_a, rd_a, err_a, busy_a);
    else n_pass++;
    n_total++;
    if ({paddr_a, psel_a, pen_a, pwr_a, pwd_a} !== '0)
      $display("FAIL reset_apb: got %h %h %b %b %h want 0",
               paddr_a, psel_a, pen_a, pwr_a, pwd_a);
    else n_pass++;
    n_total++;
    if ({ack_b, busy_b, psel_b} !== '0)
      $display("FAIL reset_b: got %h %b %h want 0",
               ack_b, busy_b, psel_b);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single_read;
    do_reset();
    REQ_ADDR[31:0] = 32'h0000_0310;
    REQ_WRITE = 4'b0000;
    PRDATA = 32'h0000_00A5;
    PREADY = 1'b1;
    REQ = 4'b0001;
    tick();
    n_total++;
    if ({psel_a, pen_a, busy_a, paddr_a} !==
        {16'h0008, 1'b0, 1'b1, 32'h0000_0310})
      $display("FAIL rd_setup: psel=%h pen=%b busy=%b addr=%h",
               psel_a, pen_a, busy_a, paddr_a);
    else n_pass++;
    tick();
    n_total++;
    if ({psel_a, pen_a, ack_a} !== {16'h0008, 1'b1, 4'b0000})
      $display("FAIL rd_access: psel=%h pen=%b ack=%h",
               psel_a, pen_a, ack_a);
    else n_pass++;
    tick();
    n_total++;
    if ({ack_a, rd_a, err_a} !== {4'b0001, 32'h0000_00A5, 1'b0})
      $display("FAIL rd_ack: ack=%h rdata=%h err=%b want 1/a5/0",
               ack_a, rd_a, err_a);
    else n_pass++;
    n_total++;
    if ({psel_a, pen_a, busy_a} !== '0)
      $display("FAIL rd_idle: psel=%h pen=%b busy=%b want 0",
               psel_a, pen_a, busy_a);
    else n_pass++;
    REQ = '0;
    tick();
    n_total++;
    if ({ack_a, busy_a, rd_a} !== '0)
      $display("FAIL rd_pulse: ack=%h busy=%b rdata=%h want 0",
               ack_a, busy_a, rd_a);
    else n_pass++;
  endtask

  task automatic test_fairness;
    logic [3:0] exp;
    int w;
    do_reset();
    for (int i = 0; i < 4; i++)
      REQ_ADDR[32*i +: 32] = 32'h0000_0100 * i;
    REQ_WRITE = 4'b0000;
    PREADY = 1'b1;
    REQ = 4'hF;
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % 4);
      w = 0;
      do begin
        tick();
        w++;
      end while (ack_a == 4'b0000 && w < 6);
      n_total++;
      if (ack_a !== exp)
        $display("FAIL rr_order[%0d]: ack=%h want %h", t, ack_a, exp);
      else n_pass++;
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_wait_states;
    do_reset();
    REQ_ADDR[63:32] = 32'h0000_0A24;
    REQ_WDATA[63:32] = 32'hDEAD_BEEF;
    REQ_WRITE = 4'b0010;
    PRDATA = 32'h1111_2222;
    PREADY = 1'b0;
    REQ = 4'b0010;
    tick();
    n_total++;
    if ({psel_a, pen_a, pwr_a, pwd_a} !==
        {16'h0400, 1'b0, 1'b1, 32'hDEAD_BEEF})
      $display("FAIL ws_setup: psel=%h pen=%b pwr=%b pwd=%h",
               psel_a, pen_a, pwr_a, pwd_a);
    else n_pass++;
    tick();
    for (int c = 1; c <= 6; c++) begin
      n_total++;
      if ({paddr_a, pwd_a, psel_a, pen_a, ack_a} !==
          {32'h0000_0A24, 32'hDEAD_BEEF, 16'h0400, 1'b1, 4'b0000})
        $display("FAIL ws_hold[%0d]: addr=%h pwd=%h psel=%h pen=%b ack=%h",
                 c, paddr_a, pwd_a, psel_a, pen_a, ack_a);
      else n_pass++;
      if (c == 6) PREADY = 1'b1;
      tick();
    end
    n_total++;
    if ({ack_a, err_a, rd_a} !== {4'b0010, 1'b0, 32'h0})
      $display("FAIL ws_ack: ack=%h err=%b rdata=%h want 2/0/0",
               ack_a, err_a, rd_a);
    else n_pass++;
    REQ = '0;
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    REQ_ADDR[31:0] = 32'h0000_0500;
    REQ_WRITE = 4'b0000;
    PRDATA = 32'h0000_1234;
    PREADY = 1'b0;
    REQ = 4'b0001;
    tick();
    tick();
    for (int c = 1; c <= 5; c++) begin
      n_total++;
      if ({ack_b, pen_b, psel_b} !== {4'b0000, 1'b1, 16'h0020})
        $display("FAIL to_wait[%0d]: ack=%h pen=%b psel=%h",
                 c, ack_b, pen_b, psel_b);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({ack_b, err_b, rd_b, psel_b} !==
        {4'b0001, 1'b1, 32'h0, 16'h0000})
      $display("FAIL to_ack: ack=%h err=%b rdata=%h psel=%h want 1/1/0/0",
               ack_b, err_b, rd_b, psel_b);
    else n_pass++;
    n_total++;
    if ({ack_a, busy_a} !== {4'b0000, 1'b1})
      $display("FAIL to_long: ack=%h busy=%b want 0/1", ack_a, busy_a);
    else n_pass++;
    REQ = '0;
  endtask

  task automatic test_slverr;
    do_reset();
    REQ_ADDR[31:0] = 32'h0000_0F00;
    REQ_ADDR[95:64] = 32'h0000_0200;
    REQ_WRITE = 4'b0000;
    PRDATA = 32'h0000_0077;
    PREADY = 1'b1;
    PSLVERR = 1'b1;
    REQ = 4'b0001;
    tick();
    tick();
    tick();
    n_total++;
    if ({ack_a, err_a, rd_a} !== {4'b0001, 1'b1, 32'h77})
      $display("FAIL serr_ack: ack=%h err=%b rdata=%h want 1/1/77",
               ack_a, err_a, rd_a);
    else n_pass++;
    PSLVERR = 1'b0;
    PRDATA = 32'h0000_0055;
    REQ = 4'b0100;
    tick();
    n_total++;
    if (psel_a !== 16'h0004)
      $display("FAIL serr_next_sel: psel=%h want 0004", psel_a);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if ({ack_a, err_a, rd_a} !== {4'b0100, 1'b0, 32'h55})
      $display("FAIL serr_next: ack=%h err=%b rdata=%h want 4/0/55",
               ack_a, err_a, rd_a);
    else n_pass++;
    REQ = '0;
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    REQ_ADDR[31:0] = 32'h0000_0100;
    REQ_ADDR[63:32] = 32'h0000_0200;
    REQ_ADDR[127:96] = 32'h0000_0300;
    REQ_WRITE = 4'b0000;
    PRDATA = 32'h0000_0099;
    PREADY = 1'b0;
    REQ = 4'b0010;
    tick();
    tick();
    n_total++;
    if ({busy_a, pen_a} !== 2'b11)
      $display("FAIL rst_pre: busy=%b pen=%b want 1/1", busy_a, pen_a);
    else n_pass++;
    PRESETN = 1'b0;
    PREADY = 1'b1;
    tick();
    n_total++;
    if ({ack_a, rd_a, err_a, busy_a, paddr_a, psel_a,
         pen_a, pwr_a, pwd_a} !== '0)
      $display("FAIL rst_mid: ack=%h busy=%b psel=%h pen=%b addr=%h",
               ack_a, busy_a, psel_a, pen_a, paddr_a);
    else n_pass++;
    PRESETN = 1'b1;
    REQ = 4'b1001;
    tick();
    n_total++;
    if ({psel_a, ack_a, paddr_a} !== {16'h0002, 4'b0000, 32'h100})
      $display("FAIL rst_regrant: psel=%h ack=%h addr=%h want 0002/0/100",
               psel_a, ack_a, paddr_a);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (ack_a !== 4'b0001)
      $display("FAIL rst_ack: ack=%h want 1", ack_a);
    else n_pass++;
    REQ = '0;
    tick();
  endtask

  initial begin
    PRESETN = 1'b0;
    REQ = '0;
    REQ_WRITE = '0;
    REQ_ADDR = '0;
    REQ_WDATA = '0;
    PRDATA = '0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    test_reset();
    test_single_read();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
